bhr_tracker: RTL and testbench
==============================

Name: bhr_tracker

Overview:
- Speculative global branch-history manager. It sits directly upstream of the gshare predictor.
- Supplies the predictor's read-side history (rd_bhr) at fetch. Checkpoints the pre-update history for each in-flight branch, and returns it at resolve as the predictor's write-side history (wr_bhr).
- On a mispredict, restores the history from the checkpoint and squashes all younger checkpoints.
- Checkpoints are freed in order at retire.

Parameters:
- BHR_DEPTH, `BRANCH_HISTORY_REG_SZ, width of the global history register.
- CKPT_DEPTH, 8, number of in-flight branch checkpoints. Must be a power of two and ≥2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fetch_valid  in  1  a branch was predicted this cycle
- fetch_pred_taken  in  1  predictor's taken prediction for that branch
- fetch_bhr  out  BHR_DEPTH  current speculative history; drives predictor rd_bhr
- fetch_tag  out  $clog2(CKPT_DEPTH)  checkpoint tag assigned to the fetching branch (tail pointer)
- fetch_accept  out  1  fetch_valid accepted this cycle
- full  out  1  all checkpoints in use
- resolve_valid  in  1  a branch resolved this cycle
- resolve_tag  in  $clog2(CKPT_DEPTH)  tag of the resolving branch
- resolve_taken  in  1  actual direction
- resolve_mispredict  in  1  direction or target was mispredicted
- resolve_bhr  out  BHR_DEPTH  checkpointed history of resolve_tag; drives predictor wr_bhr (combinational read)
- retire_valid  in  1  oldest branch retired; frees the head checkpoint
- count  out  $clog2(CKPT_DEPTH)+1  live checkpoints

Behaviour:
- Reset (async, active-high) clears the following:
  - spec_bhr=0, head=0, tail=0, count=0
  - checkpoint array = 0
  - resulting outputs: fetch_bhr=0, fetch_tag=0, full=0, fetch_accept=0, resolve_bhr=0
- Reset mid-operation discards all checkpoints immediately.
- State:
  - spec_bhr register
  - circular checkpoint array ckpt[CKPT_DEPTH] of BHR_DEPTH bits
  - head/tail pointers that wrap modulo CKPT_DEPTH
  - count register, 0..CKPT_DEPTH
- full = (count == CKPT_DEPTH). fetch_accept = fetch_valid & ~full & ~(resolve_valid & resolve_mispredict).
- Fetch (accepted), effective next edge:
  - ckpt[tail] <= spec_bhr (pre-update history, i.e. what the predictor indexed with)
  - spec_bhr <= {spec_bhr[BHR_DEPTH-2:0], fetch_pred_taken}
  - tail <= tail+1
  - count +1
- fetch_bhr and fetch_tag are combinational from current state. The predictor sees history and tag in the same cycle (zero latency).
- Correct resolve (resolve_valid & ~resolve_mispredict): no state change. resolve_bhr is still valid for the predictor update.
- Mispredict (resolve_valid & resolve_mispredict):
  - spec_bhr <= {ckpt[resolve_tag][BHR_DEPTH-2:0], resolve_taken}
  - tail <= resolve_tag+1; younger checkpoints are squashed
  - count <= ((resolve_tag − head) mod CKPT_DEPTH) + 1 − retire_valid
- Retire: head <= head+1, count −1. Must not be asserted when count==0 (assertion).
- Simultaneous events:
  - Mispredict + fetch: mispredict wins; the fetch is dropped (fetch_accept=0). Upstream is redirecting anyway.
  - Fetch + retire: count unchanged; head and tail both advance.
  - Fetch when full: not accepted. spec_bhr and tail are unchanged.
  - Mispredict + retire where resolve_tag==head: the head frees; count becomes 0 and tail==head+1==new head.
  - Full + retire + fetch_valid: the fetch is still refused this cycle; full is evaluated on registered count.
- resolve_tag must lie within [head, tail) modulo wrap; an out-of-range tag is illegal (assertion).
- BHR_DEPTH==1 edge: the shift degenerates to {fetch_pred_taken}. Use a generate or equivalent form so it stays legal.

Decomposition:
- sys_defs.svh:
  - BHR_T typedef (logic [`BRANCH_HISTORY_REG_SZ-1:0])
  - `BRANCH_CKPT_SZ define (default 8)
  - CKPT_TAG typedef
- One natural sub-module: bhr_ckpt_buf. It is the circular checkpoint array with head/tail/count, one write port and one async read port. bhr_tracker owns spec_bhr and the event arbitration.

Test Plan (BHR_DEPTH=4, CKPT_DEPTH=4):
- Reset, then 3 fetches with taken=1,0,1 → fetch_tag 0,1,2; fetch_bhr 0000, 0001, 0010, final 0101; count=3.
- 4 fetches then a 5th fetch_valid → full=1, fetch_accept=0 on the 5th; spec_bhr and tail unchanged. Retire once → full=0, and the next fetch gets tag 0 (wrap).
- After the first scenario, mispredict tag=1 with resolve_taken=1 → resolve_bhr=0001 in the same cycle. Next cycle: spec_bhr=0011, tail=2, count=2.
- Mispredict tag=0 and fetch_valid in the same cycle → fetch_accept=0; spec_bhr={ckpt0[2:0],taken}, count=1.
- Head at 3, tail wrapped to 1, mispredict tag=3 with retire_valid → count=0; head=tail=0; spec_bhr restored from ckpt3.
- Assert reset asynchronously mid-cycle with count=3 → all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/bhr_tracker_pkg.sv
// Shared sizing defaults and types for the speculative branch-history tracker.
package bhr_tracker_pkg;

  localparam int BRANCH_HISTORY_REG_SZ = 8;
  localparam int BRANCH_CKPT_SZ        = 8;

  typedef logic [BRANCH_HISTORY_REG_SZ-1:0]         bhr_t;
  typedef logic [$clog2(BRANCH_CKPT_SZ)-1:0]        ckpt_tag_t;

endpackage

// File: rtl/bhr_ckpt_buf.sv
// Circular checkpoint store: one write port at tail, one async read port,
// head/tail/count bookkeeping with mispredict rollback of the tail.
module bhr_ckpt_buf #(
  parameter int BHR_DEPTH  = 8,
  parameter int CKPT_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [BHR_DEPTH-1:0]          push_bhr,
  input  logic                          pop,
  input  logic                          restore,
  input  logic [$clog2(CKPT_DEPTH)-1:0] restore_tag,
  input  logic [$clog2(CKPT_DEPTH)-1:0] rd_tag,
  output logic [BHR_DEPTH-1:0]          rd_bhr,
  output logic [$clog2(CKPT_DEPTH)-1:0] head,
  output logic [$clog2(CKPT_DEPTH)-1:0] tail,
  output logic [$clog2(CKPT_DEPTH):0]   count
);
  localparam int TW = $clog2(CKPT_DEPTH);

  logic [BHR_DEPTH-1:0] ckpt [CKPT_DEPTH];
  logic [TW-1:0]        span;

  // distance from head to the restoring entry; wraps because depth is a power of two
  assign span   = restore_tag - head;
  assign rd_bhr = ckpt[rd_tag];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CKPT_DEPTH; i++) ckpt[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) ckpt[tail] <= push_bhr;
      if (pop)  head <= head + TW'(1);
      if (restore) begin
        tail  <= restore_tag + TW'(1);
        count <= (TW+1)'(span) + (TW+1)'(1) - (TW+1)'(pop);
      end else begin
        tail  <= tail + TW'(push);
        count <= count + (TW+1)'(push) - (TW+1)'(pop);
      end
    end
  end

endmodule

// File: rtl/bhr_tracker.sv
// Speculative global history manager feeding the gshare predictor: owns the
// speculative history and arbitrates fetch, resolve/mispredict and retire.
module bhr_tracker
  import bhr_tracker_pkg::*;
#(
  parameter int BHR_DEPTH  = BRANCH_HISTORY_REG_SZ,
  parameter int CKPT_DEPTH = BRANCH_CKPT_SZ
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          fetch_valid,
  input  logic                          fetch_pred_taken,
  output logic [BHR_DEPTH-1:0]          fetch_bhr,
  output logic [$clog2(CKPT_DEPTH)-1:0] fetch_tag,
  output logic                          fetch_accept,
  output logic                          full,
  input  logic                          resolve_valid,
  input  logic [$clog2(CKPT_DEPTH)-1:0] resolve_tag,
  input  logic                          resolve_taken,
  input  logic                          resolve_mispredict,
  output logic [BHR_DEPTH-1:0]          resolve_bhr,
  input  logic                          retire_valid,
  output logic [$clog2(CKPT_DEPTH):0]   count
);
  localparam int TW = $clog2(CKPT_DEPTH);

  logic [BHR_DEPTH-1:0] spec_bhr;
  logic [BHR_DEPTH-1:0] shifted_bhr;
  logic [BHR_DEPTH-1:0] restored_bhr;
  logic [TW-1:0]        head;
  logic [TW-1:0]        tail;
  logic [TW-1:0]        resolve_span;
  logic                 mispredict;

  assign mispredict   = resolve_valid & resolve_mispredict;
  assign full         = (count == (TW+1)'(CKPT_DEPTH));
  // a mispredict redirects fetch, so any same-cycle fetch is dropped
  assign fetch_accept = fetch_valid & ~full & ~mispredict;
  assign fetch_bhr    = spec_bhr;
  assign fetch_tag    = tail;
  assign resolve_span = resolve_tag - head;

  generate
    if (BHR_DEPTH == 1) begin : g_narrow
      assign shifted_bhr  = fetch_pred_taken;
      assign restored_bhr = resolve_taken;
    end else begin : g_wide
      assign shifted_bhr  = {spec_bhr[BHR_DEPTH-2:0], fetch_pred_taken};
      assign restored_bhr = {resolve_bhr[BHR_DEPTH-2:0], resolve_taken};
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             spec_bhr <= '0;
    else if (mispredict)   spec_bhr <= restored_bhr;
    else if (fetch_accept) spec_bhr <= shifted_bhr;
  end

  bhr_ckpt_buf #(
    .BHR_DEPTH  (BHR_DEPTH),
    .CKPT_DEPTH (CKPT_DEPTH)
  ) u_ckpt_buf (
    .clock       (clock),
    .reset       (reset),
    .push        (fetch_accept),
    .push_bhr    (spec_bhr),
    .pop         (retire_valid),
    .restore     (mispredict),
    .restore_tag (resolve_tag),
    .rd_tag      (resolve_tag),
    .rd_bhr      (resolve_bhr),
    .head        (head),
    .tail        (tail),
    .count       (count)
  );

  a_retire_nonempty: assert property (@(posedge clock) disable iff (reset)
    retire_valid |-> count != '0);
  a_resolve_in_flight: assert property (@(posedge clock) disable iff (reset)
    resolve_valid |-> {1'b0, resolve_span} < count);

endmodule

// File: tb/tb_bhr_tracker.sv
// Scoreboard bench for bhr_tracker at BHR_DEPTH=4, CKPT_DEPTH=4.
module tb_bhr_tracker;

  logic       clock = 1'b0;
  logic       reset;
  logic       fetch_valid, fetch_pred_taken;
  logic [3:0] fetch_bhr;
  logic [1:0] fetch_tag;
  logic       fetch_accept, full;
  logic       resolve_valid, resolve_taken, resolve_mispredict;
  logic [1:0] resolve_tag;
  logic [3:0] resolve_bhr;
  logic       retire_valid;
  logic [2:0] count;

  typedef struct packed {
    logic [3:0] fbhr;
    logic [1:0] ftag;
    logic       acc;
    logic       full;
    logic [3:0] rbhr;
    logic [2:0] cnt;
  } obs_t;

  obs_t obs;
  obs_t exp_q[$];
  obs_t exp_v;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] m_bhr;
  logic [3:0] m_ckpt [4];
  int         m_head, m_tail, m_count;

  always #5 clock = ~clock;

  assign obs = '{fbhr: fetch_bhr, ftag: fetch_tag, acc: fetch_accept,
                 full: full, rbhr: resolve_bhr, cnt: count};

  bhr_tracker #(.BHR_DEPTH(4), .CKPT_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pred_taken(fetch_pred_taken),
    .fetch_bhr(fetch_bhr), .fetch_tag(fetch_tag), .fetch_accept(fetch_accept),
    .full(full), .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
    .resolve_bhr(resolve_bhr), .retire_valid(retire_valid), .count(count)
  );

  task automatic model_reset();
    m_bhr = '0; m_head = 0; m_tail = 0; m_count = 0;
    for (int i = 0; i < 4; i++) m_ckpt[i] = '0;
  endtask

  // Drive one cycle of stimulus at the falling edge; push the expected
  // combinational outputs for this cycle and advance the model past the next edge.
  task automatic drive(input logic fv, input logic ft, input logic rv,
                       input logic [1:0] rtag, input logic rtaken,
                       input logic rmis, input logic ret);
    logic mis, acc;
    @(negedge clock);
    fetch_valid = fv; fetch_pred_taken = ft; resolve_valid = rv;
    resolve_tag = rtag; resolve_taken = rtaken; resolve_mispredict = rmis;
    retire_valid = ret;
    mis = rv & rmis;
    acc = fv & (m_count != 4) & ~mis;
    exp_q.push_back('{fbhr: m_bhr, ftag: 2'(m_tail), acc: acc, full: (m_count == 4),
                      rbhr: m_ckpt[rtag], cnt: 3'(m_count)});
    if (mis) begin
      m_bhr   = {m_ckpt[rtag][2:0], rtaken};
      m_count = ((int'(rtag) - m_head) & 3) + 1 - int'(ret);
      m_tail  = (int'(rtag) + 1) % 4;
    end else if (acc) begin
      m_ckpt[m_tail] = m_bhr;
      m_bhr   = {m_bhr[2:0], ft};
      m_tail  = (m_tail + 1) % 4;
      m_count = m_count + 1 - int'(ret);
    end else if (ret) begin
      m_count = m_count - 1;
    end
    if (ret) m_head = (m_head + 1) % 4;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_compare(input string name);
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, observed %h", name, obs);
    end else begin
      exp_v = exp_q.pop_front();
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s: observed %h required %h", name, obs, exp_v);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    fetch_valid = 0; fetch_pred_taken = 0; resolve_valid = 0; resolve_tag = 0;
    resolve_taken = 0; resolve_mispredict = 0; retire_valid = 0;
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_state: observed %h required 0", obs);
    end
  endtask

  task automatic test_fetch_seq();
    logic [3:0] want_bhr [3];
    logic       taken    [3];
    want_bhr = '{4'b0000, 4'b0001, 4'b0010};
    taken    = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, taken[i], 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      pop_compare("fetch_seq");
      n_tests++;
      if (fetch_tag !== 2'(i) || fetch_bhr !== want_bhr[i]) begin
        n_fail++;
        $display("FAIL fetch_seq_plan: tag %0d bhr %b required tag %0d bhr %b",
                 fetch_tag, fetch_bhr, i, want_bhr[i]);
      end
    end
    idle();
    pop_compare("fetch_seq_final");
    n_tests++;
    if (fetch_bhr !== 4'b0101 || count !== 3'd3) begin
      n_fail++;
      $display("FAIL fetch_seq_final_plan: bhr %b count %0d required 0101 3", fetch_bhr, count);
    end
  endtask

  task automatic test_mispredict();
    drive(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    pop_compare("mispredict");
    n_tests++;
    if (resolve_bhr !== 4'b0001) begin
      n_fail++;
      $display("FAIL mispredict_rbhr: observed %b required 0001", resolve_bhr);
    end
    idle();
    pop_compare("mispredict_after");
    n_tests++;
    if (fetch_bhr !== 4'b0011 || fetch_tag !== 2'd2 || count !== 3'd2) begin
      n_fail++;
      $display("FAIL mispredict_after_plan: bhr %b tag %0d count %0d required 0011 2 2",
               fetch_bhr, fetch_tag, count);
    end
    drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    pop_compare("correct_resolve");
  endtask

  task automatic test_mispredict_fetch();
    drive(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    pop_compare("mispredict_fetch");
    n_tests++;
    if (fetch_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL mispredict_fetch_accept: observed %b required 0", fetch_accept);
    end
    idle();
    pop_compare("mispredict_fetch_after");
    n_tests++;
    if (fetch_bhr !== 4'b0001 || count !== 3'd1 || fetch_tag !== 2'd1) begin
      n_fail++;
      $display("FAIL mispredict_fetch_plan: bhr %b count %0d tag %0d required 0001 1 1",
               fetch_bhr, count, fetch_tag);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[0], 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      pop_compare("full_fill");
    end
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    pop_compare("full_refuse");
    n_tests++;
    if (full !== 1'b1 || fetch_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL full_plan: full %b accept %b required 1 0", full, fetch_accept);
    end
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    pop_compare("full_retire_fetch");
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    pop_compare("full_wrap_fetch");
    n_tests++;
    if (full !== 1'b0 || fetch_tag !== 2'd0 || fetch_accept !== 1'b1) begin
      n_fail++;
      $display("FAIL full_wrap_plan: full %b tag %0d accept %b required 0 0 1",
               full, fetch_tag, fetch_accept);
    end
    idle();
    pop_compare("full_again");
  endtask

  task automatic test_wrap_mispredict_retire();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      pop_compare("wrap_fill");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      pop_compare("wrap_drain");
    end
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    pop_compare("wrap_fetch3");
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    pop_compare("wrap_fetch0");
    drive(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1);
    pop_compare("wrap_mis_retire");
    idle();
    pop_compare("wrap_after");
    n_tests++;
    // ckpt3 held 0111 (three taken fetches), restored with taken=0
    if (count !== 3'd0 || fetch_tag !== 2'd0 || fetch_bhr !== 4'b1110) begin
      n_fail++;
      $display("FAIL wrap_plan: count %0d tag %0d bhr %b required 0 0 1110",
               count, fetch_tag, fetch_bhr);
    end
  endtask

  task automatic test_back_to_back();
    logic fv, ft, rv, rm, ret;
    logic [1:0] rtag;
    apply_reset();
    for (int c = 0; c < 60; c++) begin
      fv  = ($urandom_range(0, 3) != 0);
      ft  = $urandom_range(0, 1);
      ret = (m_count > 0) && ($urandom_range(0, 2) == 0);
      rv  = (m_count > 0) && ($urandom_range(0, 2) == 0);
      rm  = rv && ($urandom_range(0, 1) == 1);
      rtag = (m_count > 0) ? 2'((m_head + int'($urandom_range(0, 31)) % m_count) % 4)
                           : 2'd0;
      drive(fv, ft, rv, rtag, ft ^ 1'b1, rm, ret);
      pop_compare("back_to_back");
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      pop_compare("async_fill");
    end
    @(negedge clock);
    fetch_valid = 0; resolve_valid = 0; retire_valid = 0; resolve_tag = 2'd0;
    #1;
    n_tests++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL async_pre: count %0d required 3", count);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL async_reset: observed %h required 0", obs);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    fetch_valid = 0; fetch_pred_taken = 0; resolve_valid = 0; resolve_tag = 0;
    resolve_taken = 0; resolve_mispredict = 0; retire_valid = 0;
    model_reset();
    test_reset();
    test_fetch_seq();
    test_mispredict();
    test_mispredict_fetch();
    test_full();
    test_wrap_mispredict_retire();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
